// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake between a producer and uart_tx_frame
//   tx_valid  producer has a word on tx_data
//   tx_ready  transmitter accepts the word this cycle
//   tx_data   word to send, LSB first on the line
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, 5..9 data bits, optional parity, 1 or 2 stop bits
//   Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the serialiser.
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   txi         valid/ready word handshake (slave side of uart_tx_frame_if)
//   tx          serial line, idle high, registered
//   busy        frame in progress or words still queued
//   fifo_count  FIFO occupancy, constant 0 when the FIFO is not built
module uart_tx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int BAUD_DIV   = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_frame_if.slave              txi,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx_frame: BAUD_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, nxt;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg, ld_data;
    logic                 par_q, load, last_bit, last_stop;

    assign last_bit  = baud_cnt == BAUD_LAST;
    assign last_stop = state == STOP && last_bit && bit_cnt == STOP_LAST;

`ifdef UART_TX_FIFO_EN
    localparam int FW = $clog2(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [FW-1:0]        wr_ptr, rd_ptr;
    logic [FW:0]          count;
    logic                 push;

    // Full blocks pushes even when a pop happens on the same edge.
    assign txi.tx_ready = !rst && count != (FW+1)'(FIFO_DEPTH);
    assign push         = txi.tx_valid && txi.tx_ready;
    // The serialiser takes the head whenever it can start a new frame.
    assign load         = count != '0 && (state == IDLE || last_stop);
    assign ld_data      = mem[rd_ptr];
    assign fifo_count   = count;
    assign busy         = state != IDLE || count != '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= txi.tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + FW'(push);
            rd_ptr <= rd_ptr + FW'(load);
            count  <= count + (FW+1)'(push) - (FW+1)'(load);
        end
    end
`else
    // Ready on the final stop clock too, so a waiting word starts with no idle gap.
    assign txi.tx_ready = !rst && (state == IDLE || last_stop);
    assign load         = txi.tx_valid && txi.tx_ready;
    assign ld_data      = txi.tx_data;
    assign fifo_count   = '0;
    assign busy         = state != IDLE;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = load ? START : IDLE;
            START:   nxt = last_bit ? DATA : START;
            DATA:    nxt = last_bit && bit_cnt == DATA_LAST ? (PARITY != 0 ? PAR : STOP) : DATA;
            PAR:     nxt = last_bit ? STOP : PAR;
            STOP:    nxt = last_stop ? (load ? START : IDLE) : STOP;
            default: nxt = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= nxt;
            tx       <= state == START ? 1'b0 : state == DATA ? shreg[0] : state == PAR ? par_q : 1'b1;
            baud_cnt <= load || state == IDLE || last_bit ? '0 : baud_cnt + 1'b1;
            bit_cnt  <= load || (last_bit && nxt != state) ? '0 : last_bit ? bit_cnt + 1'b1 : bit_cnt;
            if (load) begin
                shreg <= ld_data;
                par_q <= PARITY == 1 ? ~^ld_data : ^ld_data;
            end else if (state == DATA && last_bit) begin
                shreg <= shreg >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for three uart_tx_frame configurations
`timescale 1ns/1ps
module tb_uart_tx_frame;
    localparam int BD = 4;
    localparam int FD = 4;
    localparam int DBS [3] = '{8, 7, 8};
    localparam int PRS [3] = '{0, 2, 1};
    localparam int SBS [3] = '{1, 2, 1};
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [15:0] bits;
        int          n;
        int          acc;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         nvec = 0;
    int         nfail = 0;
    logic       vld [3];
    logic [8:0] dat [3];
    int         last_acc [3];
    frm_t       sb [3][$];
    frm_t       cur [3];
    logic       play [3];
    int         st [3];
    int         pend_end [3];
    logic       tx0, tx1, tx2, bsy0, bsy1, bsy2;
    logic [2:0] fc0, fc1, fc2;

    uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if2 ();

    assign if0.tx_valid = vld[0];
    assign if0.tx_data  = dat[0][7:0];
    assign if1.tx_valid = vld[1];
    assign if1.tx_data  = dat[1][6:0];
    assign if2.tx_valid = vld[2];
    assign if2.tx_data  = dat[2][7:0];

    uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) dut0 (
        .clk(clk), .rst(rst), .txi(if0.slave), .tx(tx0), .busy(bsy0), .fifo_count(fc0));
    uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(FD)) dut1 (
        .clk(clk), .rst(rst), .txi(if1.slave), .tx(tx1), .busy(bsy1), .fifo_count(fc1));
    uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(FD)) dut2 (
        .clk(clk), .rst(rst), .txi(if2.slave), .tx(tx2), .busy(bsy2), .fifo_count(fc2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic txs(input int i);
        return i == 0 ? tx0 : i == 1 ? tx1 : tx2;
    endfunction

    function automatic logic rdys(input int i);
        return i == 0 ? if0.tx_ready : i == 1 ? if1.tx_ready : if2.tx_ready;
    endfunction

    function automatic logic bsys(input int i);
        return i == 0 ? bsy0 : i == 1 ? bsy1 : bsy2;
    endfunction

    function automatic logic [2:0] fcs(input int i);
        return i == 0 ? fc0 : i == 1 ? fc1 : fc2;
    endfunction

    // Line image of one frame: start, data LSB first, optional parity, stop bits.
    function automatic frm_t mk(input int id, input logic [8:0] d, input int acc);
        frm_t f;
        logic p;
        int   n;
        f     = '0;
        f.acc = acc;
        p     = 1'b0;
        for (int i = 0; i < DBS[id]; i++) begin
            f.bits[1+i] = d[i];
            p ^= d[i];
        end
        n = 1 + DBS[id];
        if (PRS[id] != 0) begin
            f.bits[n] = PRS[id] == 2 ? p : ~p;
            n++;
        end
        for (int s = 0; s < SBS[id]; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.n = n;
        return f;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, id, cyc, act, req);
        end
    endtask

    task automatic send(input int id, input logic [8:0] d);
        dat[id] = d;
        vld[id] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rdys(id)) begin
                sb[id].push_back(mk(id, d, cyc + 1));
                last_acc[id] = cyc + 1;
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("accept_timeout", id, 0, 1);
    endtask

    function automatic logic idle_all(input int id);
        return sb[id].size() == 0 && !play[id];
    endfunction

    task automatic wait_idle(input int id);
        for (int n = 0; n < 3000 && !idle_all(id); n++) @(negedge clk);
        chk("drain", id, 32'(idle_all(id)), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: replays each expected frame against the line, one comparison per clock.
    initial begin
        int exp_s;
        for (int i = 0; i < 3; i++) begin
            play[i]     = 1'b0;
            pend_end[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    play[i] = 1'b0;
                    sb[i].delete();
                    pend_end[i] = 0;
                end else if (play[i]) begin
                    chk("bit", i, 32'(txs(i)), 32'(cur[i].bits[(cyc - st[i]) / BD]));
                    if (cyc == st[i] + cur[i].n * BD - 1) begin
                        play[i]     = 1'b0;
                        pend_end[i] = cyc + 1;
                    end
                end else if (sb[i].size() == 0) begin
                    chk("idle", i, 32'(txs(i)), 1);
                end else begin
                    exp_s = sb[i][0].acc + LAT > pend_end[i] ? sb[i][0].acc + LAT : pend_end[i];
                    if (cyc < exp_s) begin
                        chk("wait", i, 32'(txs(i)), 1);
                    end else begin
                        chk("start", i, 32'(txs(i)), 0);
                        cur[i]  = sb[i].pop_front();
                        play[i] = 1'b1;
                        st[i]   = cyc;
                    end
                end
            end
        end
    end

    task automatic rand_drv(input int id);
        for (int j = 0; j < 25; j++) begin
            send(id, 9'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                vld[id] = 1'b0;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
            end
        end
        vld[id] = 1'b0;
    endtask

    initial begin
        int a;
        int pk;
        int accs [6];
        for (int i = 0; i < 3; i++) begin
            vld[i]      = 1'b0;
            dat[i]      = '0;
            last_acc[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", i, 32'(txs(i)), 1);
            chk("rst_ready", i, 32'(rdys(i)), 0);
            chk("rst_busy", i, 32'(bsys(i)), 0);
            chk("rst_fifo_count", i, 32'(fcs(i)), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ready_after_rst", i, 32'(rdys(i)), 1);
        @(posedge clk);
        #1;

        fork
            begin
                send(0, 9'h055);
                vld[0] = 1'b0;
                repeat (3) @(negedge clk);
                chk("busy_mid", 0, 32'(bsy0), 1);
            end
            begin
                send(1, 9'h003);
                vld[1] = 1'b0;
            end
            begin
                send(2, 9'h000);
                vld[2] = 1'b0;
                wait_idle(2);
                send(2, 9'h0FF);
                vld[2] = 1'b0;
            end
        join
        for (int i = 0; i < 3; i++) wait_idle(i);
        for (int i = 0; i < 3; i++) chk("busy_idle", i, 32'(bsys(i)), 0);

        send(0, 9'h0A5);
        a = last_acc[0];
        send(0, 9'h03C);
        vld[0] = 1'b0;
`ifndef UART_TX_FIFO_EN
        chk("b2b_accept", 0, 32'(last_acc[0] - a), 40);
`endif
        wait_idle(0);

        send(0, 9'h0C3);
        vld[0] = 1'b0;
        a = last_acc[0];
        while (cyc < a + LAT + 17) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tx", 0, 32'(tx0), 1);
        chk("rst_mid_busy", 0, 32'(bsy0), 0);
        chk("rst_mid_fifo", 0, 32'(fc0), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(0, 9'h05A);
        vld[0] = 1'b0;
        wait_idle(0);

        fork
            rand_drv(0);
            rand_drv(1);
            rand_drv(2);
        join
        for (int i = 0; i < 3; i++) wait_idle(i);

        pk = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(0, 9'($urandom));
                    accs[k] = last_acc[0];
                end
                vld[0] = 1'b0;
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (int'(fc0) > pk) pk = int'(fc0);
                end
            end
        join
`ifdef UART_TX_FIFO_EN
        chk("fifo_peak", 0, 32'(pk), 4);
        chk("fifo_burst", 0, 32'(accs[4] - accs[0]), 4);
        chk("fifo_full_stall", 0, 32'(accs[5] - accs[4] > 1), 1);
`else
        chk("fifo_count_zero", 0, 32'(pk), 0);
        for (int k = 1; k < 6; k++) chk("b2b_spacing", 0, 32'(accs[k] - accs[k-1]), 40);
`endif
        wait_idle(0);
        for (int i = 0; i < 3; i++) chk("busy_end", i, 32'(bsys(i)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
